// File: rtl/serial_compare_ctrl.sv
// MSB-first serial magnitude compare sequencer: one bit per clock, early exit
// on the first differing bit, with a start/busy/done handshake and registered result.
module serial_compare_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CW-1:0]    bits_used
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic             abit, bbit;

  // 1-bit comparator stage always looks at the current MSB of the shifters
  assign abit = sa[WIDTH-1];
  assign bbit = sb[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      idx       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      bits_used <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            idx   <= CW'(WIDTH-1);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (abit != bbit || idx == '0) begin
            // abit/bbit directly encode gt/lt; equal bits here mean idx hit 0
            gt        <= abit & ~bbit;
            lt        <= ~abit & bbit;
            eq        <= (abit == bbit);
            bits_used <= cnt + CW'(1);
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            sa  <= sa << 1;
            sb  <= sb << 1;
            idx <= idx - CW'(1);
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl: constant vector table, hand-written corner
// sequences, and random operands checked against an arithmetic reference.
module tb_serial_compare_ctrl;
  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst, start;
  logic [W-1:0]  a, b;
  logic          busy, done, gt, eq, lt;
  logic [CW-1:0] bits_used;

  int total = 0;
  int bad   = 0;

  serial_compare_ctrl #(.WIDTH(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt), .bits_used(bits_used)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va, vb;
    int g, e, l, k;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: relational operators for the result, highest differing bit for the count
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                output int g, output int e, output int l, output int k);
    bit found;
    g = int'(x > y);
    e = int'(x == y);
    l = int'(x < y);
    k = W;
    found = 1'b0;
    for (int i = W-1; i >= 0; i--)
      if (!found && x[i] != y[i]) begin
        k = W - i;
        found = 1'b1;
      end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmp(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input int eg, input int ee, input int el, input int ek);
    int cyc;
    a = xa; b = xb; start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, " busy_after_accept"}, int'(busy), 1);
    cyc = 0;
    while (!done && cyc < W + 4) begin
      tick();
      cyc++;
    end
    chk({name, " done"}, int'(done), 1);
    chk({name, " latency"}, cyc, ek);
    chk({name, " gt"}, int'(gt), eg);
    chk({name, " eq"}, int'(eq), ee);
    chk({name, " lt"}, int'(lt), el);
    chk({name, " bits_used"}, int'(bits_used), ek);
    chk({name, " busy_at_done"}, int'(busy), 0);
    tick();
    chk({name, " done_one_cycle"}, int'(done), 0);
  endtask

  initial begin
    int ndone, dcyc, g, e, l, k, errs;
    logic [W-1:0] ra, rb;

    vecs[0] = '{8'hA5, 8'h5A, 1, 0, 0, 1};
    vecs[1] = '{8'h3C, 8'h3D, 0, 0, 1, 8};
    vecs[2] = '{8'h77, 8'h77, 0, 1, 0, 8};
    vecs[3] = '{8'h40, 8'h00, 1, 0, 0, 2};
    vecs[4] = '{8'h10, 8'h20, 0, 0, 1, 3};
    vecs[5] = '{8'h00, 8'h00, 0, 1, 0, 8};
    vecs[6] = '{8'hFF, 8'hFE, 1, 0, 0, 8};
    vecs[7] = '{8'h00, 8'h80, 0, 0, 1, 1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset gt", int'(gt), 0);
    chk("reset eq", int'(eq), 0);
    chk("reset lt", int'(lt), 0);
    chk("reset bits_used", int'(bits_used), 0);

    for (int i = 0; i < 8; i++)
      do_cmp($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb,
             vecs[i].g, vecs[i].e, vecs[i].l, vecs[i].k);

    // Result must stay put while idle
    do_cmp("hold_setup", 8'h3C, 8'h3D, 0, 0, 1, 8);
    errs = 0;
    for (int c = 0; c < 20; c++) begin
      a = W'($urandom); b = W'($urandom);
      tick();
      if (done || busy || gt || eq || !lt || bits_used != CW'(8)) errs++;
    end
    chk("idle_hold errors", errs, 0);

    // Second start during SCAN is ignored
    a = 8'h01; b = 8'h00; start = 1'b1;
    tick();
    ndone = 0; dcyc = 0; g = 0; k = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) begin start = 1'b1; a = 8'hFF; b = 8'h00; end
      else start = 1'b0;
      tick();
      if (done) begin ndone++; dcyc = c; g = int'(gt); k = int'(bits_used); end
    end
    chk("ignore_start ndone", ndone, 1);
    chk("ignore_start done_cycle", dcyc, 8);
    chk("ignore_start gt", g, 1);
    chk("ignore_start bits_used", k, 8);

    // Reset mid-SCAN discards the comparison
    a = 8'h0F; b = 8'h0E; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset busy", int'(busy), 0);
    chk("midreset done", int'(done), 0);
    chk("midreset gt", int'(gt), 0);
    chk("midreset eq", int'(eq), 0);
    chk("midreset lt", int'(lt), 0);
    chk("midreset bits_used", int'(bits_used), 0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("midreset no_activity", ndone, 0);
    do_cmp("after_reset", 8'h10, 8'h20, 0, 0, 1, 3);

    // Continuous start: accept/finish alternate with no idle gap
    a = 8'h80; b = 8'h00; start = 1'b1;
    errs = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (int'(busy) != (i % 2)) errs++;
      if (int'(done) != ((i % 2) == 0 ? 1 : 0)) errs++;
      if (i % 2 == 0 && (!gt || eq || lt || bits_used != CW'(1))) errs++;
    end
    chk("back_to_back errors", errs, 0);
    start = 1'b0;
    tick(); tick();

    // Random operands against the reference; bias toward long scans
    for (int n = 0; n < 300; n++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0: rb = W'($urandom);
        1: rb = ra;
        default: rb = ra ^ (W'(1) << $urandom_range(0, W-1));
      endcase
      model(ra, rb, g, e, l, k);
      do_cmp($sformatf("rnd%0d", n), ra, rb, g, e, l, k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_compare_ctrl.md
Name: serial_compare_ctrl

Overview:
Sequencer that drives a 1-bit magnitude comparator stage across two WIDTH-bit operands. It runs MSB-first, one bit per clock, and stops early on the first differing bit. It sits between a requester and the 1-bit compare datapath, adds a start/busy/done handshake, and registers the greater/equal/less result.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32)
CW, $clog2(WIDTH+1), width of the bit-count output

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a comparison; accepted only in IDLE
a  input  WIDTH  operand A; sampled on the accepting edge only
b  input  WIDTH  operand B; sampled on the accepting edge only
busy  output  1  high while in SCAN
done  output  1  one-cycle pulse when a result becomes valid
gt  output  1  A > B (mirrors 1-bit comparator output x)
eq  output  1  A == B (mirrors y)
lt  output  1  A < B (mirrors z)
bits_used  output  CW  number of bit positions examined for the last result (1..WIDTH)

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy=0, done=0, gt=0, eq=0, lt=0, bits_used=0; internal shift registers and index cleared.
- Reset wins over every other input, including mid-SCAN. An in-flight comparison is discarded with no done pulse.
- States: IDLE, SCAN. There is no separate DONE state.
- IDLE, start=1: capture a/b into shift registers sa/sb; set index=WIDTH-1 and count=0; go to SCAN. busy=1 from the next cycle.
  - gt/eq/lt/bits_used keep their previous result until the new result is written.
- IDLE, start=0: hold all state; result outputs stay stable indefinitely.
- SCAN, each cycle: 1-bit compare of abit=sa[WIDTH-1] and bbit=sb[WIDTH-1].
  - abit=1, bbit=0: gt=1, eq=0, lt=0; go to IDLE.
  - abit=0, bbit=1: lt=1, gt=0, eq=0; go to IDLE.
  - Bits equal and index≠0: shift sa and sb left by 1, decrement index, stay in SCAN.
  - Bits equal and index=0: eq=1, gt=0, lt=0; go to IDLE.
- On every SCAN→IDLE transition, at the same edge: done=1 for exactly one cycle, bits_used=k (the number of bits compared), busy=0.
- Exactly one of gt/eq/lt is high after any completed comparison. All three are 0 only after reset, before the first result.
- Latency: start sampled at edge E0; result, done and busy=0 all visible after edge E0+k, with k in 1..WIDTH.
  - Worst case is WIDTH cycles (equal operands, or first difference at bit 0).
  - Best case is 1 cycle (MSBs differ).
- start while busy=1: ignored, no queuing. a/b changes during SCAN have no effect.
- start in the done cycle: the FSM is already in IDLE, so it is accepted. This gives back-to-back comparisons with zero idle cycles.
- Unsigned comparison only. No wrap-around; index never goes below 0.
- Outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, then start with a=8'hA5, b=8'h5A -> after 1 cycle: done pulse, gt=1 eq=0 lt=0, bits_used=1, busy low.
2. a=8'h3C, b=8'h3D -> busy high for 8 cycles; done, then lt=1, bits_used=8. Results hold stable for 20 idle cycles.
3. a=b=8'h77 -> eq=1, bits_used=8, done high exactly one cycle. a=8'h40, b=8'h00 -> gt=1, bits_used=2.
4. Start a=8'h01, b=8'h00. Pulse start again with a=8'hFF, b=8'h00 at cycle 3 of SCAN -> second start ignored; result gt=1, bits_used=8; only one done pulse.
5. Start a=8'h0F, b=8'h0E. Assert rst at cycle 4 of SCAN -> next cycle all outputs 0, busy=0, no done pulse. A fresh start a=8'h10, b=8'h20 -> lt=1, bits_used=3.
6. Hold start=1 continuously with a=8'h80, b=8'h00 -> done every other cycle (accept, 1-cycle SCAN). gt stays 1; busy toggles 1/0.
